// File: rtl/regfile_pkg.sv
// Shared register-file constants used by decode, writeback and the register file.
package regfile_pkg;
  localparam int DW_DEF   = 32;
  localparam int NREG_DEF = 32;
  localparam int NR_DEF   = 2;
  localparam int NW_DEF   = 1;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by a decode claim and
// cleared by a retiring write, plus the per-read-port operand-busy flags.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG),
  parameter int NR   = NR_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_claim_en,
  input  logic [AW-1:0]    i_claim_addr,
  input  logic [NREG-1:0]  i_wr_hit,
  input  logic [NR*AW-1:0] i_rd_addr,
  output logic [NR-1:0]    o_rd_busy,
  output logic [NREG-1:0]  o_busy_vec
);

  logic [NREG-1:0] r_busy;
  logic [AW-1:0]   w_ra [NR];

  // Busy bits: a claim outranks a same-cycle write, since the new producer supersedes it
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_busy <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (r == REG_ZERO) begin
          r_busy[r] <= 1'b0;
        end else if (i_claim_en && (i_claim_addr == AW'(r))) begin
          r_busy[r] <= 1'b1;
        end else if (i_wr_hit[r]) begin
          r_busy[r] <= 1'b0;
        end else begin
          r_busy[r] <= r_busy[r];
        end
      end
    end
  end

  // Operand busy: a write retiring this cycle releases the operand through the bypass
  always_comb begin
    o_rd_busy = '0;
    for (int i = 0; i < NR; i++) begin
      w_ra[i]      = i_rd_addr[i*AW +: AW];
      o_rd_busy[i] = resetn & r_busy[w_ra[i]] & ~i_wr_hit[w_ra[i]];
    end
  end

  assign o_busy_vec = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: data array, write-port conflict resolution,
// write-first bypass on every read port, and the pending-write scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG),
  parameter int NR   = NR_DEF,
  parameter int NW   = NW_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [NR*AW-1:0] rd_addr,
  output logic [NR*DW-1:0] rd_data,
  output logic [NR-1:0]    rd_busy,
  input  logic [NW-1:0]    wr_en,
  input  logic [NW*AW-1:0] wr_addr,
  input  logic [NW*DW-1:0] wr_data,
  input  logic             claim_en,
  input  logic [AW-1:0]    claim_addr,
  output logic [NREG-1:0]  busy_vec
);

  localparam int WIW = (NW > 1) ? $clog2(NW) : 1;

  logic [DW-1:0]  r_mem    [NREG];
  logic [NW-1:0]  w_wr_eff;
  logic [NREG-1:0] w_wr_hit;
  logic [WIW-1:0] w_wr_sel [NREG];
  logic [AW-1:0]  w_ra     [NR];

  // Highest-index effective port writing tgt wins; lower ports are dropped
  function automatic logic wr_winner(input  logic [NW-1:0]    eff,
                                     input  logic [NW*AW-1:0] addr,
                                     input  logic [AW-1:0]    tgt,
                                     output logic [WIW-1:0]   sel);
    logic hit;
    hit = 1'b0;
    sel = '0;
    for (int j = 0; j < NW; j++) begin
      if (eff[j] && (addr[j*AW +: AW] == tgt)) begin
        hit = 1'b1;
        sel = WIW'(j);
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction

  // Effective writes exclude reset and x0, which also disables the bypass
  always_comb begin
    w_wr_eff = '0;
    for (int j = 0; j < NW; j++) begin
      w_wr_eff[j] = resetn & wr_en[j] & (wr_addr[j*AW +: AW] != AW'(REG_ZERO));
    end
  end

  // Per-register winning write port
  always_comb begin
    w_wr_hit = '0;
    w_wr_sel = '{default: '0};
    for (int r = 0; r < NREG; r++) begin
      w_wr_hit[r] = wr_winner(w_wr_eff, wr_addr, AW'(r), w_wr_sel[r]);
    end
  end

  // Data array; x0 is only ever cleared by reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) r_mem[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (w_wr_hit[r]) begin
          r_mem[r] <= wr_data[w_wr_sel[r]*DW +: DW];
        end else begin
          r_mem[r] <= r_mem[r];
        end
      end
    end
  end

  // Read ports with write-first bypass
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NR; i++) begin
      w_ra[i] = rd_addr[i*AW +: AW];
      if (w_ra[i] == AW'(REG_ZERO)) begin
        rd_data[i*DW +: DW] = '0;
      end else if (w_wr_hit[w_ra[i]]) begin
        rd_data[i*DW +: DW] = wr_data[w_wr_sel[w_ra[i]]*DW +: DW];
      end else begin
        rd_data[i*DW +: DW] = r_mem[w_ra[i]];
      end
    end
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .AW   (AW),
    .NR   (NR)
  ) u_scoreboard (
    .clk          (clk),
    .resetn       (resetn),
    .i_claim_en   (claim_en),
    .i_claim_addr (claim_addr),
    .i_wr_hit     (w_wr_hit),
    .i_rd_addr    (rd_addr),
    .o_rd_busy    (rd_busy),
    .o_busy_vec   (busy_vec)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with two read and two write ports: reset,
// x0 handling, bypass, write priority and scoreboard claim/retire sequences.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int NREG = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic             clk = 1'b0;
  logic             resetn;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic             claim_en;
  logic [AW-1:0]    claim_addr;
  logic [NREG-1:0]  busy_vec;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DW(DW), .NREG(NREG), .NR(NR), .NW(NW)) dut (
    .clk(clk), .resetn(resetn), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .busy_vec(busy_vec)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        ce;
    logic [4:0]  ca;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  bz;
    logic [31:0] bv;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1, input logic ce,
                       input logic [4:0] ca, input logic [4:0] ra0, input logic [4:0] ra1);
    wr_en      = we;
    wr_addr    = {wa1, wa0};
    wr_data    = {wd1, wd0};
    claim_en   = ce;
    claim_addr = ca;
    rd_addr    = {ra1, ra0};
  endtask

  initial begin
    //            we     wa0    wd0           wa1    wd1           ce    ca     ra0    ra1    d0            d1            bz     bv
    tbl[0]  = '{2'b01, 5'd0,  32'hDEADBEEF, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 32'h0};
    tbl[1]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 32'h0};
    tbl[2]  = '{2'b01, 5'd3,  32'hA5A50001, 5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd3,  32'hA5A50001, 32'hA5A50001, 2'b00, 32'h0};
    tbl[3]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd4,  32'hA5A50001, 32'h0,        2'b00, 32'h0};
    tbl[4]  = '{2'b11, 5'd7,  32'h11,       5'd7,  32'h22,       1'b0, 5'd0,  5'd7,  5'd7,  32'h22,       32'h22,       2'b00, 32'h0};
    tbl[5]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd3,  32'h22,       32'hA5A50001, 2'b00, 32'h0};
    tbl[6]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd7,  32'h0,        32'h22,       2'b00, 32'h0};
    tbl[7]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd9,  32'h0,        32'h0,        2'b11, 32'h200};
    tbl[8]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd9,  32'h0,        32'h0,        2'b11, 32'h200};
    tbl[9]  = '{2'b10, 5'd0,  32'h0,        5'd9,  32'h55,       1'b0, 5'd0,  5'd9,  5'd3,  32'h55,       32'hA5A50001, 2'b00, 32'h200};
    tbl[10] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd9,  32'h55,       32'h55,       2'b00, 32'h0};
    tbl[11] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd9,  32'h55,       32'h55,       2'b00, 32'h0};
    tbl[12] = '{2'b01, 5'd9,  32'h66,       5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd9,  32'h66,       32'h66,       2'b00, 32'h200};
    tbl[13] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd9,  32'h66,       32'h66,       2'b11, 32'h200};
    tbl[14] = '{2'b11, 5'd12, 32'h1,        5'd13, 32'h2,        1'b0, 5'd0,  5'd12, 5'd13, 32'h1,        32'h2,        2'b00, 32'h200};
    tbl[15] = '{2'b11, 5'd9,  32'h77,       5'd9,  32'h88,       1'b0, 5'd0,  5'd9,  5'd12, 32'h88,       32'h1,        2'b00, 32'h200};
    tbl[16] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd12, 32'h88,       32'h1,        2'b00, 32'h0};

    // Power-on reset
    resetn = 1'b0;
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd2);
    @(negedge clk);
    @(negedge clk);
    chk("por_busy_vec", 64'(busy_vec), 64'h0);
    chk("por_rd_data", 64'(rd_data), 64'h0);
    chk("por_rd_busy", 64'(rd_busy), 64'h0);

    // Fill x1..x31 with all-ones through port 1
    resetn = 1'b1;
    for (int r = 1; r < 32; r++) begin
      drive(2'b10, 5'd0, 32'h0, 5'(r), 32'hFFFFFFFF, 1'b0, 5'd0, 5'(r), 5'd0);
      #1;
      chk("fill_bypass", 64'(rd_data[31:0]), 64'hFFFFFFFF);
      @(negedge clk);
    end
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd6, 5'd5, 5'd6);
    @(negedge clk);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
    #1;
    chk("pre_rst_busy_vec", 64'(busy_vec), 64'h40);
    chk("pre_rst_rd_busy", 64'(rd_busy), 64'h2);
    chk("pre_rst_rd_data", 64'(rd_data), 64'hFFFFFFFF_FFFFFFFF);
    @(negedge clk);

    // Mid-run reset: write and claim ignored, no bypass, rd_busy forced low
    resetn = 1'b0;
    drive(2'b01, 5'd5, 32'h1234, 5'd0, 32'h0, 1'b1, 5'd7, 5'd5, 5'd6);
    #1;
    chk("rst_no_bypass", 64'(rd_data[31:0]), 64'hFFFFFFFF);
    chk("rst_rd_busy", 64'(rd_busy), 64'h0);
    @(negedge clk);
    chk("rst_array_clr", 64'(rd_data), 64'h0);
    chk("rst_busy_vec", 64'(busy_vec), 64'h0);
    resetn = 1'b1;
    for (int r = 0; r < 32; r += 2) begin
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(r), 5'(r + 1));
      #1;
      chk("post_rst_read", 64'(rd_data), 64'h0);
      chk("post_rst_busy_vec", 64'(busy_vec), 64'h0);
      @(negedge clk);
    end

    // Table-driven vectors: one row per cycle, checked just before the commit edge
    for (int k = 0; k < 17; k++) begin
      drive(tbl[k].we, tbl[k].wa0, tbl[k].wd0, tbl[k].wa1, tbl[k].wd1,
            tbl[k].ce, tbl[k].ca, tbl[k].ra0, tbl[k].ra1);
      #1;
      chk($sformatf("row%0d_d0", k), 64'(rd_data[31:0]), 64'(tbl[k].d0));
      chk($sformatf("row%0d_d1", k), 64'(rd_data[63:32]), 64'(tbl[k].d1));
      chk($sformatf("row%0d_busy", k), 64'(rd_busy), 64'(tbl[k].bz));
      chk($sformatf("row%0d_bv", k), 64'(busy_vec), 64'(tbl[k].bv));
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
